// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator.
// Define MCYCLE_DIV_EN to build the divide path; without it a divide returns 0/0.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             state_dbg
);
    // Handshake: Start is a request taken only in IDLE; Busy is the stall it
    // raises from that cycle on; Done pulses one cycle when results are valid.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, COMPUTE = 1'b1} state_t;
    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic               last;
    logic               op_div;
    logic               neg_res;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc, acc_next, acc_mul, prod_fix;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   res1_fix, res2_fix;
`ifdef MCYCLE_DIV_EN
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   orig_op1;
    logic [WIDTH:0]     rem_sh, trial;
    logic [2*WIDTH-1:0] acc_div;
    logic [WIDTH-1:0]   quo_raw, rem_raw;
`endif

    assign mag1 = (Signed && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    assign mag2 = (Signed && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
    assign last = (state == COMPUTE) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = COMPUTE;
            COMPUTE: if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy      = ((state == IDLE) && Start) || (state == COMPUTE);
        state_dbg = state;
    end

    // Multiply step: conditional add into the upper half, then shift right.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        acc_mul = {add_sum, acc[WIDTH-1:1]};
    end

`ifdef MCYCLE_DIV_EN
    // Restoring step: remainder in the upper half, quotient shifts in below.
    always_comb begin
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = rem_sh - {1'b0, opb};
        acc_div = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_next = op_div ? acc_div : acc_mul;
    end
`else
    assign acc_next = acc_mul;
`endif

    always_comb begin
        prod_fix = neg_res ? -acc_next : acc_next;
        res1_fix = prod_fix[WIDTH-1:0];
        res2_fix = prod_fix[2*WIDTH-1:WIDTH];
`ifdef MCYCLE_DIV_EN
        quo_raw = acc_next[WIDTH-1:0];
        rem_raw = acc_next[2*WIDTH-1:WIDTH];
        if (op_div) begin
            if (div_zero) begin
                res1_fix = '1;
                res2_fix = orig_op1;
            end else begin
                res1_fix = neg_res ? -quo_raw : quo_raw;
                res2_fix = neg_rem ? -rem_raw : rem_raw;
            end
        end
`else
        if (op_div) begin
            res1_fix = '0;
            res2_fix = '0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            Result1  <= '0;
            Result2  <= '0;
            Done     <= 1'b0;
`ifdef MCYCLE_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            orig_op1 <= '0;
`endif
        end else begin
            Done <= last;
            if (state == IDLE && Start) begin
                cnt     <= '0;
                op_div  <= MCycleOp;
                neg_res <= Signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
`ifdef MCYCLE_DIV_EN
                neg_rem  <= Signed & Operand1[WIDTH-1];
                div_zero <= (Operand2 == '0);
                orig_op1 <= Operand1;
                opb      <= MCycleOp ? mag2 : mag1;
                acc      <= {{WIDTH{1'b0}}, (MCycleOp ? mag1 : mag2)};
`else
                opb      <= mag1;
                acc      <= {{WIDTH{1'b0}}, mag2};
`endif
            end else if (state == COMPUTE) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    Result1 <= res1_fix;
                    Result2 <= res2_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit (WIDTH=32); divide expectations follow
// whether MCYCLE_DIV_EN is defined.
module tb_mcycle_unit;
    logic        CLK = 1'b0;
    logic        RESETn;
    logic        Start;
    logic        MCycleOp;
    logic        Signed;
    logic [31:0] Operand1, Operand2;
    logic [31:0] Result1, Result2;
    logic        Busy, Done, state_dbg;

    int checks = 0;
    int failures = 0;
    int pulse_at = 0;
    int lat, bc, dn;
    logic [31:0] e1, e2;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
        .Signed(Signed), .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        MCycleOp = op;
        Signed   = sgn;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        #1;
    endtask

    // Called in the accept cycle; returns in the Done cycle (or after a budget).
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        if (Busy === 1'b1) b++;
        @(posedge CLK); #1;
        Start = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        l = 1;
        while (Done !== 1'b1 && l < 100) begin
            if (Busy === 1'b1) b++;
            if (l == pulse_at) begin
                Start    = 1'b1;
                MCycleOp = ~MCycleOp;
                Operand1 = $urandom_range(1, 1000);
                Operand2 = $urandom_range(1, 1000);
            end
            @(posedge CLK); #1;
            Start = 1'b0;
            l++;
        end
    endtask

    task automatic do_op(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bcnt);
        @(posedge CLK); #1;
        launch(op, sgn, a, b);
        wait_done(l, bcnt);
    endtask

    task automatic count_done(input int n, output int d);
        d = 0;
        repeat (n) begin
            @(posedge CLK); #1;
            if (Done === 1'b1) d++;
        end
    endtask

    initial begin
        RESETn = 1'b0; Start = 1'b0; MCycleOp = 1'b0; Signed = 1'b0;
        Operand1 = '0; Operand2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_r1", Result1, 0);
        check("rst_r2", Result2, 0);
        check("rst_state", state_dbg, 0);
        RESETn = 1'b1;

        // Unsigned 0xFFFFFFFF squared
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        check("umul_latency", lat, 33);
        check("umul_busy_cycles", bc, 33);
        check("umul_done", Done, 1);
        check("umul_busy_at_done", Busy, 0);
        check("umul_r2", Result2, 32'hFFFF_FFFE);
        check("umul_r1", Result1, 32'h0000_0001);
        @(posedge CLK); #1;
        check("umul_done_clears", Done, 0);
        check("umul_hold_r1", Result1, 32'h0000_0001);

        // Signed -7 * 6
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd6, lat, bc);
        check("smul_latency", lat, 33);
        check("smul_result", {Result2, Result1}, 64'hFFFF_FFFF_FFFF_FFD6);

        // Signed -7 / 2
`ifdef MCYCLE_DIV_EN
        e1 = 32'hFFFF_FFFD; e2 = 32'hFFFF_FFFF;
`else
        e1 = 32'h0; e2 = 32'h0;
`endif
        do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc);
        check("sdiv_latency", lat, 33);
        check("sdiv_busy_cycles", bc, 33);
        check("sdiv_q", Result1, e1);
        check("sdiv_r", Result2, e2);

        // MIN / -1
`ifdef MCYCLE_DIV_EN
        e1 = 32'h8000_0000; e2 = 32'h0;
`else
        e1 = 32'h0; e2 = 32'h0;
`endif
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        check("minneg1_q", Result1, e1);
        check("minneg1_r", Result2, e2);

        // Unsigned 100 / 0
`ifdef MCYCLE_DIV_EN
        e1 = 32'hFFFF_FFFF; e2 = 32'd100;
`else
        e1 = 32'h0; e2 = 32'h0;
`endif
        do_op(1'b1, 1'b0, 32'd100, 32'd0, lat, bc);
        check("udiv0_latency", lat, 33);
        check("udiv0_q", Result1, e1);
        check("udiv0_r", Result2, e2);

        // Signed -5 / 0
`ifdef MCYCLE_DIV_EN
        e1 = 32'hFFFF_FFFF; e2 = 32'hFFFF_FFFB;
`else
        e1 = 32'h0; e2 = 32'h0;
`endif
        do_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, lat, bc);
        check("sdiv0_q", Result1, e1);
        check("sdiv0_r", Result2, e2);

        // Unsigned 1000 / 7
`ifdef MCYCLE_DIV_EN
        e1 = 32'd142; e2 = 32'd6;
`else
        e1 = 32'h0; e2 = 32'h0;
`endif
        do_op(1'b1, 1'b0, 32'd1000, 32'd7, lat, bc);
        check("udiv_q", Result1, e1);
        check("udiv_r", Result2, e2);

        // Start pulsed mid-COMPUTE is ignored
        pulse_at = 5;
        do_op(1'b0, 1'b0, 32'd3, 32'd5, lat, bc);
        pulse_at = 0;
        check("pulse_latency", lat, 33);
        check("pulse_r1", Result1, 32'd15);
        check("pulse_r2", Result2, 32'd0);
        count_done(40, dn);
        check("pulse_no_extra_done", dn, 0);

        // Start held through Done: back-to-back operations
        do_op(1'b0, 1'b0, 32'd7, 32'd9, lat, bc);
        check("b2b_first_r1", Result1, 32'd63);
        launch(1'b0, 1'b0, 32'h0001_0000, 32'h0003_0000);
        check("b2b_busy_in_done", Busy, 1);
        wait_done(lat, bc);
        check("b2b_second_latency", lat, 33);
        check("b2b_second_r2", Result2, 32'h0000_0003);
        check("b2b_second_r1", Result1, 32'h0000_0000);

        // Reset at T10 of a divide
        @(posedge CLK); #1;
        launch(1'b1, 1'b0, 32'd1000, 32'd7);
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        check("pre_reset_busy", Busy, 1);
        RESETn = 1'b0;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_r1", Result1, 0);
        check("abort_r2", Result2, 0);
        @(posedge CLK); #1;
        RESETn = 1'b1;
        count_done(40, dn);
        check("abort_no_done", dn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
